// File: rtl/elbeth_mux_pkg.sv
// elbeth_mux_pkg: shared mode constants and flattened-bus slice helper
package elbeth_mux_pkg;
  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR = 1;
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/elbeth_rr_arbiter.sv
// elbeth_rr_arbiter: combinational round-robin pick; ports req[N], ptr -> grant_idx, grant_vld
module elbeth_rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant_idx,
  output logic         grant_vld
);
  always_comb begin
    int j;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        grant_vld = 1'b1;
        grant_idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/elbeth_mux_n_to_1_pipe.sv
// elbeth_mux_n_to_1_pipe: registered N:1 valid/ready selector (explicit sel or round-robin); in_data/in_valid/in_ready per channel, sel, out_data/out_valid/out_ready/out_chan
module elbeth_mux_n_to_1_pipe
  import elbeth_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN = 4,
  parameter int MODE = MUX_MODE_SEL,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_chan
);
  logic r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_chan, w_c;
  logic w_cvld, w_can_accept, w_xfer;
  assign w_can_accept = !r_valid | out_ready;
  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic [SEL_W-1:0] r_ptr;
      logic w_unused_sel;
      assign w_unused_sel = ^sel;
      elbeth_rr_arbiter #(.N(N_IN)) u_arb (
        .req(in_valid),
        .ptr(r_ptr),
        .grant_idx(w_c),
        .grant_vld(w_cvld)
      );
      always_ff @(posedge clk or posedge rst)
        if (rst) r_ptr <= '0;
        else if (w_xfer) r_ptr <= (32'(w_c) == N_IN - 1) ? '0 : w_c + 1'b1;
    end else begin : g_sel
      assign w_c = sel;
      assign w_cvld = 32'(sel) < N_IN;
    end
  endgenerate
  // rst gates ready directly: the cleared register alone would otherwise advertise space
  assign in_ready = (rst | !w_can_accept | !w_cvld) ? '0 : N_IN'(1) << w_c;
  assign w_xfer = |(in_ready & in_valid);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_chan <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data <= in_data[slice_lo(int'(w_c), WIDTH) +: WIDTH];
      r_chan <= w_c;
    end else if (out_ready) r_valid <= 1'b0;
  assign out_data = r_data;
  assign out_valid = r_valid;
  assign out_chan = r_chan;
endmodule

// File: tb/tb_elbeth_mux_n_to_1_pipe.sv
// tb_elbeth_mux_n_to_1_pipe: random + directed check of three configurations against a reference model
module tb_elbeth_mux_n_to_1_pipe;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic [31:0] dat [3][4];
  logic [3:0] vld [3];
  logic [1:0] sel_s [3];
  logic ordy [3];
  logic [127:0] a_data, b_data;
  logic [95:0] c_data;
  logic [2:0] c_rdy;
  logic [31:0] obs_data [3];
  logic obs_valid [3];
  logic [1:0] obs_chan [3];
  logic [3:0] obs_rdy [3];
  logic [3:0] a_rdy, b_rdy;
  assign a_data = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
  assign b_data = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
  assign c_data = {dat[2][2], dat[2][1], dat[2][0]};
  assign obs_rdy[0] = a_rdy;
  assign obs_rdy[1] = b_rdy;
  assign obs_rdy[2] = {1'b0, c_rdy};
  elbeth_mux_n_to_1_pipe #(.WIDTH(32), .N_IN(4), .MODE(0)) d0 (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(vld[0]), .in_ready(a_rdy), .sel(sel_s[0]),
    .out_data(obs_data[0]), .out_valid(obs_valid[0]), .out_ready(ordy[0]), .out_chan(obs_chan[0]));
  elbeth_mux_n_to_1_pipe #(.WIDTH(32), .N_IN(4), .MODE(1)) d1 (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(vld[1]), .in_ready(b_rdy), .sel(sel_s[1]),
    .out_data(obs_data[1]), .out_valid(obs_valid[1]), .out_ready(ordy[1]), .out_chan(obs_chan[1]));
  elbeth_mux_n_to_1_pipe #(.WIDTH(32), .N_IN(3), .MODE(0)) d2 (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(vld[2][2:0]), .in_ready(c_rdy), .sel(sel_s[2]),
    .out_data(obs_data[2]), .out_valid(obs_valid[2]), .out_ready(ordy[2]), .out_chan(obs_chan[2]));
  int n_vec = 0, n_err = 0;
  int m_valid [3], m_chan [3], m_ptr [3];
  logic [31:0] m_data [3];
  logic [31:0] sbq [$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic int nin(input int u);
    return u == 2 ? 3 : 4;
  endfunction
  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      m_valid[u] = 0;
      m_data[u] = '0;
      m_chan[u] = 0;
      m_ptr[u] = 0;
    end
    sbq.delete();
  endtask
  task automatic cycle();
    bit xf [3];
    logic [31:0] xd [3];
    int xc [3];
    #1;
    for (int u = 0; u < 3; u++) begin
      int n, c;
      bit cv;
      logic [3:0] er;
      n = nin(u);
      c = 0;
      cv = 0;
      if (u != 1) begin
        c = int'(sel_s[u]);
        cv = c < n;
      end else
        for (int i = 0; i < n; i++) begin
          int k;
          k = (m_ptr[u] + i) % n;
          if (!cv && vld[u][k]) begin
            cv = 1;
            c = k;
          end
        end
      er = (cv && (m_valid[u] == 0 || ordy[u])) ? 4'(1 << c) : 4'b0;
      chk($sformatf("rdy%0d", u), obs_rdy[u], er);
      xf[u] = er != 0 && vld[u][c];
      xd[u] = dat[u][c % 4];
      xc[u] = c;
    end
    if (obs_valid[0] && ordy[0]) begin
      if (sbq.size() > 0) chk("sb_order", obs_data[0], sbq.pop_front());
      else chk("sb_underflow", 32'(sbq.size()), 1);
    end
    if (xf[0]) sbq.push_back(xd[0]);
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      if (xf[u]) begin
        m_valid[u] = 1;
        m_data[u] = xd[u];
        m_chan[u] = xc[u];
        if (u == 1) m_ptr[u] = (xc[u] + 1) % nin(u);
      end else if (ordy[u]) m_valid[u] = 0;
      chk($sformatf("valid%0d", u), obs_valid[u], m_valid[u]);
      chk($sformatf("data%0d", u), obs_data[u], m_data[u]);
      chk($sformatf("chan%0d", u), obs_chan[u], m_chan[u]);
    end
  endtask
  task automatic randomize_inputs(input bit rnd_ready);
    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 4; k++) dat[u][k] = $urandom;
      vld[u] = 4'($urandom);
      sel_s[u] = 2'($urandom);
      if (rnd_ready) ordy[u] = $urandom_range(0, 3) != 0;
    end
  endtask
  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 4; k++) dat[u][k] = '0;
      vld[u] = '0;
      sel_s[u] = '0;
      ordy[u] = 1'b0;
    end
    model_reset();
    #2;
    for (int u = 0; u < 3; u++) begin
      chk("rst_valid", obs_valid[u], 0);
      chk("rst_data", obs_data[u], 0);
      chk("rst_chan", obs_chan[u], 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    dat[0][0] = 32'hDEADBEEF;
    for (int u = 0; u < 3; u++) vld[u] = 4'hF;
    cycle();
    chk("idle_capture", obs_data[0], 32'hDEADBEEF);
    cycle();
    cycle();
    ordy[0] = 1'b1;
    for (int k = 0; k < 4; k++) dat[0][k] = 32'h1000 + k;
    for (int k = 0; k < 4; k++) begin
      sel_s[0] = 2'(k);
      cycle();
      chk("sweep_data", obs_data[0], 32'h1000 + k);
      chk("sweep_chan", obs_chan[0], k);
    end
    sel_s[2] = 2'd3;
    ordy[2] = 1'b1;
    cycle();
    chk("oor_valid", obs_valid[2], 0);
    chk("oor_rdy", obs_rdy[2], 0);
    for (int u = 0; u < 3; u++) ordy[u] = 1'b0;
    sel_s[2] = 2'd0;
    cycle();
    rst = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) begin
      chk("async_valid", obs_valid[u], 0);
      chk("async_rdy", obs_rdy[u], 0);
      chk("async_data", obs_data[u], 0);
    end
    #2;
    rst = 1'b0;
    model_reset();
    ordy[1] = 1'b1;
    vld[1] = 4'hF;
    for (int k = 0; k < 4; k++) dat[1][k] = 32'hA0 + k;
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("rr_seq", obs_chan[1], i % 4);
    end
    vld[1] = 4'b0100;
    cycle();
    chk("rr_only2", obs_chan[1], 2);
    vld[1] = 4'hF;
    cycle();
    chk("rr_after2", obs_chan[1], 3);
    for (int i = 0; i < 40; i++) begin
      randomize_inputs(1'b0);
      for (int u = 0; u < 3; u++) ordy[u] = (i % 4 == 0) || (i % 4 == 3);
      cycle();
    end
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(1'b1);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
